// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator for the Pong datapath.
//
// A prescaler divides clk into pixel ticks. x and y count pixels and lines
// and are read by the paddle and ball logic. The output stage is registered:
// hsync and vsync (both active-low), endofframe, and the blank-gated colour.
// All of these appear one clk after the x/y they were computed from.
//
// Optional build macro: VGA_TEST_PATTERN_EN. When it is defined, rgb_in is
// ignored and the visible area shows eight vertical colour bars.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   rgb_in     in   {red[2:0], green[2:0], blue[1:0]} from the graphics mux
//   x, y       out  current pixel / line counters
//   video_on   out  combinational: x/y lie in the visible area
//   pixel_tick out  one-clk pulse on the clk where the counters advance
//   endofframe out  registered: high while y is in vertical blanking
//   hsync      out  registered, active-low
//   vsync      out  registered, active-low
//   red, green, blue  out  registered, blank-gated colour
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       endofframe,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [2:0] DIV_LAST     = 3'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [2:0] div_q, div_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       eof_q, eof_d;
    logic [7:0] rgb_q, rgb_d;
    logic [7:0] pix_colour;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_DISPLAY / 8);
    logic [2:0] bar_idx;
    logic       unused_rgb_in;
    assign unused_rgb_in = ^rgb_in;
`endif

    // Prescaler and raster counters
    always_comb begin
        // Gated by reset_n so that CLK_DIV = 1 shows no tick while in reset
        pixel_tick = reset_n && (div_q == DIV_LAST);
        div_d      = pixel_tick ? 3'd0 : div_q + 3'd1;
        x_d        = x_q;
        y_d        = y_q;
        if (pixel_tick) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Output stage: computed from the current counters every clk
    always_comb begin
        video_on = (x_q < H_DISP) && (y_q < V_DISP);
        hsync_d  = !((x_q >= H_SYNC_FIRST) && (x_q <= H_SYNC_LAST));
        vsync_d  = !((y_q >= V_SYNC_FIRST) && (y_q <= V_SYNC_LAST));
        eof_d    = (y_q >= V_DISP);
`ifdef VGA_TEST_PATTERN_EN
        bar_idx    = 3'(x_q / BAR_W);
        pix_colour = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}};
`else
        pix_colour = rgb_in;
`endif
        rgb_d = video_on ? pix_colour : 8'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= 3'd0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            eof_q   <= 1'b0;
            rgb_q   <= 8'd0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            eof_q   <= eof_d;
            rgb_q   <= rgb_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    // Driven straight from a flop because downstream logic clocks on it
    assign endofframe = eof_q;
    assign red        = rgb_q[7:5];
    assign green      = rgb_q[4:2];
    assign blue       = rgb_q[1:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. It runs three instances side by side:
//   a: default 640x480 timing, CLK_DIV = 2
//   b: small 80x55 raster, CLK_DIV = 2, so whole frames stay short
//   c: the same small raster with CLK_DIV = 1
// The expected outputs come from a closed-form model. After k clk edges
// since reset release, the pixel index is k/CLK_DIV modulo the frame size.
// The registered outputs are derived from the previous pixel position.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rgb_in = 8'd0;

    always #5 clk = ~clk;

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic       vid_a, tick_a, eof_a, hs_a, vs_a;
    logic       vid_b, tick_b, eof_b, hs_b, vs_b;
    logic       vid_c, tick_c, eof_c, hs_c, vs_c;
    logic [2:0] r_a, g_a, r_b, g_b, r_c, g_c;
    logic [1:0] b_a, b_b, b_c;

    vga_sync_gen u_a (
        .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in), .x(x_a), .y(y_a),
        .video_on(vid_a), .pixel_tick(tick_a), .endofframe(eof_a), .hsync(hs_a),
        .vsync(vs_a), .red(r_a), .green(g_a), .blue(b_a)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in), .x(x_b), .y(y_b),
        .video_on(vid_b), .pixel_tick(tick_b), .endofframe(eof_b), .hsync(hs_b),
        .vsync(vs_b), .red(r_b), .green(g_b), .blue(b_b)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_c (
        .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in), .x(x_c), .y(y_c),
        .video_on(vid_c), .pixel_tick(tick_c), .endofframe(eof_c), .hsync(hs_c),
        .vsync(vs_c), .red(r_c), .green(g_c), .blue(b_c)
    );

    logic [32:0] out_a, out_b, out_c;
    assign out_a = {x_a, y_a, vid_a, tick_a, eof_a, hs_a, vs_a, r_a, g_a, b_a};
    assign out_b = {x_b, y_b, vid_b, tick_b, eof_b, hs_b, vs_b, r_b, g_b, b_b};
    assign out_c = {x_c, y_c, vid_c, tick_c, eof_c, hs_c, vs_c, r_c, g_c, b_c};

    int n_cmp = 0;
    int n_bad = 0;

    // Count of clk edges since reset release, and rgb_in as seen by each edge
    int unsigned k;
    logic [7:0]  rgb_at_edge;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end
    always @(posedge clk) rgb_at_edge <= rgb_in;

    function automatic logic [32:0] model(input int unsigned kk, input bit in_rst,
                                          input logic [7:0] rgb, input int unsigned d,
                                          input int unsigned hd, input int unsigned hf,
                                          input int unsigned hs, input int unsigned hb,
                                          input int unsigned vd, input int unsigned vf,
                                          input int unsigned vs, input int unsigned vb);
        int unsigned ht, vt, p, xx, yy, xp, yp, bar;
        logic        vid, tick, eof, hsn, vsn;
        logic [7:0]  col;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        xx = 0; yy = 0; tick = 1'b0; eof = 1'b0; hsn = 1'b1; vsn = 1'b1; col = 8'd0;
        if (!in_rst) begin
            p    = (kk / d) % (ht * vt);
            xx   = p % ht;
            yy   = p / ht;
            tick = ((kk + 1) % d) == 0;
            if (kk != 0) begin
                p   = ((kk - 1) / d) % (ht * vt);
                xp  = p % ht;
                yp  = p / ht;
                hsn = !(xp >= hd + hf && xp < hd + hf + hs);
                vsn = !(yp >= vd + vf && yp < vd + vf + vs);
                eof = yp >= vd;
`ifdef VGA_TEST_PATTERN_EN
                bar = xp / (hd / 8);
                col = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
`else
                bar = 0;
                col = rgb;
`endif
                if (!(xp < hd && yp < vd)) col = 8'd0;
            end
        end
        vid = (xx < hd) && (yy < vd);
        return {10'(xx), 10'(yy), vid, tick, eof, hsn, vsn, col};
    endfunction

    function automatic logic [32:0] exp_a();
        return model(k, !reset_n, rgb_at_edge, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic logic [32:0] exp_b();
        return model(k, !reset_n, rgb_at_edge, 2, 64, 4, 8, 4, 48, 2, 2, 3);
    endfunction
    function automatic logic [32:0] exp_c();
        return model(k, !reset_n, rgb_at_edge, 1, 64, 4, 8, 4, 48, 2, 2, 3);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        rgb_in  = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (out_a !== exp_a()) begin
                n_bad++; $display("FAIL reset_a got %h exp %h", out_a, exp_a());
            end
            n_cmp++;
            if (out_c !== exp_c()) begin
                n_bad++; $display("FAIL reset_c got %h exp %h", out_c, exp_c());
            end
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (out_c !== exp_c()) begin
            n_bad++; $display("FAIL release_c got %h exp %h", out_c, exp_c());
        end
        @(negedge clk);
        n_cmp++;
        if (x_a !== 10'd0) begin
            n_bad++; $display("FAIL first_edge_x got %0d exp 0", x_a);
        end
        @(negedge clk);
        n_cmp++;
        if (x_a !== 10'd1) begin
            n_bad++; $display("FAIL second_edge_x got %0d exp 1", x_a);
        end
    endtask

    task automatic test_stream(input string name, input int n, input bit rand_rgb);
        for (int i = 0; i < n; i++) begin
            rgb_in = rand_rgb ? 8'($urandom) : 8'hFF;
            @(negedge clk);
            n_cmp++;
            if (out_a !== exp_a()) begin
                n_bad++; $display("FAIL %s_a k=%0d got %h exp %h", name, k, out_a, exp_a());
            end
            n_cmp++;
            if (out_b !== exp_b()) begin
                n_bad++; $display("FAIL %s_b k=%0d got %h exp %h", name, k, out_b, exp_b());
            end
            n_cmp++;
            if (out_c !== exp_c()) begin
                n_bad++; $display("FAIL %s_c k=%0d got %h exp %h", name, k, out_c, exp_c());
            end
        end
    endtask

    task automatic test_line_timing();
        int   t;
        int   w;
        logic prev;
        prev = hs_a;
        for (t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (prev && !hs_a) break;
            prev = hs_a;
        end
        n_cmp++;
        if (t >= 4000) begin
            n_bad++; $display("FAIL hsync_fall_timeout got none exp fall");
            return;
        end
        n_cmp++;
        if (x_a !== 10'd656) begin
            n_bad++; $display("FAIL hsync_fall_x got %0d exp 656", x_a);
        end
        for (w = 0; !hs_a && w < 4000; w++) @(negedge clk);
        n_cmp++;
        if (w != 192) begin
            n_bad++; $display("FAIL hsync_low_width got %0d exp 192", w);
        end
        prev = hs_a;
        for (t = w; t < 4000; t++) begin
            @(negedge clk);
            if (prev && !hs_a) break;
            prev = hs_a;
        end
        n_cmp++;
        if (t + 1 != 1600) begin
            n_bad++; $display("FAIL hsync_period got %0d exp 1600", t + 1);
        end
    endtask

    task automatic test_frame_timing();
        int   t;
        int   w;
        logic prev;
        // vsync on instance b: 2 lines of 80 px at 2 clks/px low, 8800 clk frame
        prev = vs_b;
        for (t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (prev && !vs_b) break;
            prev = vs_b;
        end
        for (w = 0; !vs_b && w < 20000; w++) @(negedge clk);
        n_cmp++;
        if (w != 320) begin
            n_bad++; $display("FAIL vsync_low_width got %0d exp 320", w);
        end
        prev = vs_b;
        for (t = w; t < 20000; t++) begin
            @(negedge clk);
            if (prev && !vs_b) break;
            prev = vs_b;
        end
        n_cmp++;
        if (t + 1 != 8800) begin
            n_bad++; $display("FAIL vsync_period got %0d exp 8800", t + 1);
        end
        // endofframe on instance b: high for 7 lines = 1120 clks
        prev = eof_b;
        for (t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (!prev && eof_b) break;
            prev = eof_b;
        end
        n_cmp++;
        if (y_b !== 10'd48 || x_b !== 10'd0) begin
            n_bad++; $display("FAIL eof_rise_pos got x=%0d y=%0d exp x=0 y=48", x_b, y_b);
        end
        for (w = 0; eof_b && w < 20000; w++) @(negedge clk);
        n_cmp++;
        if (w != 1120) begin
            n_bad++; $display("FAIL eof_high_width got %0d exp 1120", w);
        end
        prev = eof_b;
        for (t = w; t < 20000; t++) begin
            @(negedge clk);
            if (!prev && eof_b) break;
            prev = eof_b;
        end
        n_cmp++;
        if (t + 1 != 8800) begin
            n_bad++; $display("FAIL eof_period got %0d exp 8800", t + 1);
        end
    endtask

    task automatic test_wrap();
        int t;
        for (t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (x_b == 10'd79 && y_b == 10'd54 && tick_b) break;
        end
        n_cmp++;
        if (t >= 20000) begin
            n_bad++; $display("FAIL wrap_timeout got none exp corner");
            return;
        end
        @(negedge clk);
        n_cmp++;
        if (x_b !== 10'd0 || y_b !== 10'd0 || eof_b !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_pos got x=%0d y=%0d eof=%b exp 0 0 1", x_b, y_b, eof_b);
        end
        @(negedge clk);
        n_cmp++;
        if (eof_b !== 1'b0) begin
            n_bad++; $display("FAIL wrap_eof_fall got %b exp 0", eof_b);
        end
    endtask

    task automatic test_midframe_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_a !== exp_a()) begin
            n_bad++; $display("FAIL midreset_a got %h exp %h", out_a, exp_a());
        end
        n_cmp++;
        if (out_b !== exp_b()) begin
            n_bad++; $display("FAIL midreset_b got %h exp %h", out_b, exp_b());
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (out_b !== exp_b()) begin
            n_bad++; $display("FAIL midrelease_b got %h exp %h", out_b, exp_b());
        end
    endtask

    initial begin
        test_reset();
        test_stream("stream", 12000, 1'b1);
        test_line_timing();
        test_stream("blanking", 1800, 1'b0);
        test_frame_timing();
        test_wrap();
        test_midframe_reset();
        test_stream("after_reset", 400, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
